// File: rtl/uart_cmd_responder.sv
// Host-side command responder for UartTop: parses 5-byte request frames, accesses a local
// byte register file and sends back a 5-byte response through the transmit handshake.
module uart_cmd_responder #(
  parameter int ADDR_W      = 4,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_word,
  input  logic       rx_rxne,
  output logic       rx_clear,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_busy,
  output logic [7:0] ctrl_reg,
  output logic       frame_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int TW    = $clog2(TIMEOUT_CYC + 1);

  localparam logic [7:0] REQ_SYNC  = 8'hA5;
  localparam logic [7:0] RESP_SYNC = 8'h5A;
  localparam logic [7:0] CMD_WR    = 8'h01;
  localparam logic [7:0] CMD_RD    = 8'h02;
  localparam logic [7:0] ST_OK     = 8'h00;
  localparam logic [7:0] ST_CHK    = 8'h01;
  localparam logic [7:0] ST_CMD    = 8'h02;
  localparam logic [7:0] ST_ADDR   = 8'h03;

  typedef enum logic [3:0] {
    IDLE, GET_CMD, GET_ADDR, GET_DATA, GET_CHK, EXEC, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO
  } state_t;

  function automatic logic [7:0] frame_chk(input logic [7:0] a, input logic [7:0] b,
                                           input logic [7:0] c);
    return a ^ b ^ c;
  endfunction

  state_t            state_r;
  logic              armed_r;
  logic [7:0]        cmd_r;
  logic [7:0]        addr_r;
  logic [7:0]        data_r;
  logic [7:0]        chk_r;
  logic [7:0]        resp_r [0:4];
  logic [2:0]        idx_r;
  logic [TW-1:0]     tmo_r;
  logic [7:0]        regs_r [0:DEPTH-1];

  logic              rx_state_s;
  logic              consume_s;
  logic [7:0]        status_s;
  logic [7:0]        rd_data_s;
  logic [7:0]        resp_data_s;
  logic [ADDR_W-1:0] waddr_s;

  assign ctrl_reg = regs_r[0];
  assign waddr_s  = addr_r[ADDR_W-1:0];

  // Bytes are only taken while parsing; during EXEC/TX they stay pending in UartTop.
  always_comb begin
    rx_state_s = 1'b0;
    if (state_r == IDLE || state_r == GET_CMD || state_r == GET_ADDR ||
        state_r == GET_DATA || state_r == GET_CHK) begin
      rx_state_s = 1'b1;
    end else begin
      rx_state_s = 1'b0;
    end
    consume_s = rx_rxne && armed_r && rx_state_s;
  end

  // Response status with checksum taking priority over command, then address.
  always_comb begin
    status_s  = ST_OK;
    rd_data_s = regs_r[waddr_s];
    if (frame_chk(cmd_r, addr_r, data_r) != chk_r) begin
      status_s = ST_CHK;
    end else if (cmd_r != CMD_WR && cmd_r != CMD_RD) begin
      status_s = ST_CMD;
    end else if ({1'b0, addr_r} >= 9'(DEPTH)) begin
      status_s = ST_ADDR;
    end else begin
      status_s = ST_OK;
    end
    if (status_s != ST_OK) begin
      resp_data_s = 8'h00;
    end else if (cmd_r == CMD_WR) begin
      resp_data_s = data_r;
    end else begin
      resp_data_s = rd_data_s;
    end
  end

  // Frame FSM, RX handshake, timeout, register file and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      armed_r   <= 1'b1;
      rx_clear  <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= 8'h00;
      frame_err <= 1'b0;
      cmd_r     <= 8'h00;
      addr_r    <= 8'h00;
      data_r    <= 8'h00;
      chk_r     <= 8'h00;
      idx_r     <= 3'd0;
      tmo_r     <= '0;
      for (int i = 0; i < 5; i++) resp_r[i] <= 8'h00;
      for (int i = 0; i < DEPTH; i++) regs_r[i] <= 8'h00;
    end else begin
      rx_clear  <= consume_s;
      tx_valid  <= 1'b0;
      frame_err <= 1'b0;
      // A byte is consumed once; re-arm only after RXNE has been seen low.
      if (!rx_rxne) begin
        armed_r <= 1'b1;
      end else if (consume_s) begin
        armed_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          tmo_r <= '0;
          if (consume_s && rx_word == REQ_SYNC) state_r <= GET_CMD;
        end
        GET_CMD, GET_ADDR, GET_DATA, GET_CHK: begin
          if (consume_s) begin
            tmo_r <= '0;
            case (state_r)
              GET_CMD:  begin cmd_r  <= rx_word; state_r <= GET_ADDR; end
              GET_ADDR: begin addr_r <= rx_word; state_r <= GET_DATA; end
              GET_DATA: begin data_r <= rx_word; state_r <= GET_CHK;  end
              GET_CHK:  begin chk_r  <= rx_word; state_r <= EXEC;     end
              default:  state_r <= IDLE;
            endcase
          end else if (tmo_r == TW'(TIMEOUT_CYC - 1)) begin
            tmo_r     <= '0;
            frame_err <= 1'b1;
            state_r   <= IDLE;
          end else begin
            tmo_r <= tmo_r + 1'b1;
          end
        end
        EXEC: begin
          if (status_s == ST_OK && cmd_r == CMD_WR) regs_r[waddr_s] <= data_r;
          resp_r[0] <= RESP_SYNC;
          resp_r[1] <= status_s;
          resp_r[2] <= addr_r;
          resp_r[3] <= resp_data_s;
          resp_r[4] <= frame_chk(status_s, addr_r, resp_data_s);
          idx_r     <= 3'd0;
          frame_err <= (status_s != ST_OK);
          state_r   <= TX_LOAD;
        end
        TX_LOAD: begin
          if (!tx_busy) begin
            tx_data  <= resp_r[idx_r];
            tx_valid <= 1'b1;
            state_r  <= TX_WAIT_HI;
          end
        end
        TX_WAIT_HI: begin
          if (tx_busy) state_r <= TX_WAIT_LO;
        end
        TX_WAIT_LO: begin
          if (!tx_busy) begin
            if (idx_r == 3'd4) begin
              state_r <= IDLE;
            end else begin
              idx_r   <= idx_r + 3'd1;
              state_r <= TX_LOAD;
            end
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Scoreboard bench for uart_cmd_responder: directed request frames with hand-computed responses;
// a monitor checks every transmitted byte against the expected queue.
module tb_uart_cmd_responder;

  localparam int TMO = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_word = 8'h00;
  logic       rx_rxne = 1'b0;
  logic       rx_clear;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_busy;
  logic [7:0] ctrl_reg;
  logic       frame_err;
  logic       model_busy = 1'b0;
  logic       force_busy = 1'b0;

  int n_vec = 0;
  int n_err = 0;
  int clr_cnt = 0;
  int ferr_cnt = 0;
  int txv_cnt = 0;
  logic [7:0] exp_q [$];

  assign tx_busy = model_busy | force_busy;

  uart_cmd_responder #(.ADDR_W(4), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .rx_word(rx_word), .rx_rxne(rx_rxne), .rx_clear(rx_clear),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy), .ctrl_reg(ctrl_reg),
    .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Pulse counters.
  initial forever begin
    @(negedge clk);
    if (rx_clear) clr_cnt++;
    if (frame_err) ferr_cnt++;
    if (tx_valid) txv_cnt++;
  end

  // Scoreboard monitor: compare each transmitted byte against the expected queue.
  initial forever begin
    @(negedge clk);
    if (tx_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL tx_byte: got 0x%02h, expected no byte", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (tx_data !== e) begin
          n_err++;
          $display("FAIL tx_byte: got 0x%02h, expected 0x%02h", tx_data, e);
        end
      end
    end
  end

  // Transmitter model: busy rises a cycle after a load and stays high for six cycles.
  initial forever begin
    @(negedge clk);
    if (tx_valid) begin
      @(negedge clk);
      model_busy = 1'b1;
      repeat (6) @(negedge clk);
      model_busy = 1'b0;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int t;
    t = 0;
    @(negedge clk);
    rx_word = b;
    rx_rxne = 1'b1;
    while (!rx_clear && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) begin
      n_vec++;
      n_err++;
      $display("FAIL rx_clear_wait: got no rx_clear, expected one for byte 0x%02h", b);
    end
    rx_rxne = 1'b0;
    @(negedge clk);
  endtask

  task automatic send_frame(input logic [39:0] req, input logic [39:0] resp, input bit has_resp);
    logic [39:0] r;
    r = resp;
    if (has_resp) for (int i = 4; i >= 0; i--) exp_q.push_back(r[i*8 +: 8]);
    r = req;
    for (int i = 4; i >= 0; i--) send_byte(r[i*8 +: 8]);
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", exp_q.size(), 0);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    int c0, f0, v0, t;
    repeat (3) @(negedge clk);
    check("rst_rx_clear", rx_clear, 0);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_ctrl", ctrl_reg, 0);
    check("rst_frame_err", frame_err, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write reg3, read it back, write reg0.
    c0 = clr_cnt;
    send_frame(40'hA5_01_03_7E_7C, 40'h5A_00_03_7E_7D, 1'b1);
    check("wr_clears", clr_cnt - c0, 5);
    drain();
    send_frame(40'hA5_02_03_00_01, 40'h5A_00_03_7E_7D, 1'b1);
    drain();
    send_frame(40'hA5_01_00_55_54, 40'h5A_00_00_55_55, 1'b1);
    check("ctrl_reg", ctrl_reg, 8'h55);
    drain();

    // Error statuses and register protection.
    send_frame(40'hA5_01_02_33_30, 40'h5A_00_02_33_31, 1'b1);
    drain();
    f0 = ferr_cnt;
    send_frame(40'hA5_01_02_11_00, 40'h5A_01_02_00_03, 1'b1);
    drain();
    check("badchk_ferr", ferr_cnt - f0, 1);
    send_frame(40'hA5_02_02_00_00, 40'h5A_00_02_33_31, 1'b1);
    drain();
    send_frame(40'hA5_07_01_00_06, 40'h5A_02_01_00_03, 1'b1);
    drain();
    send_frame(40'hA5_02_10_00_12, 40'h5A_03_10_00_13, 1'b1);
    drain();
    send_frame(40'hA5_07_01_00_00, 40'h5A_01_01_00_00, 1'b1);
    drain();
    send_frame(40'hA5_01_0F_A5_AB, 40'h5A_00_0F_A5_AA, 1'b1);
    drain();

    // Garbage and a long RXNE level before a valid frame.
    c0 = clr_cnt;
    @(negedge clk);
    rx_word = 8'h00;
    rx_rxne = 1'b1;
    repeat (10) @(negedge clk);
    rx_rxne = 1'b0;
    repeat (2) @(negedge clk);
    check("held_rxne_clears", clr_cnt - c0, 1);
    send_byte(8'hFF);
    send_byte(8'h13);
    send_frame(40'hA5_02_03_00_01, 40'h5A_00_03_7E_7D, 1'b1);
    drain();

    // Timeout after a partial frame.
    f0 = ferr_cnt;
    v0 = txv_cnt;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TMO + 20) @(negedge clk);
    check("tmo_ferr", ferr_cnt - f0, 1);
    check("tmo_no_tx", txv_cnt - v0, 0);
    send_frame(40'hA5_02_0F_00_0D, 40'h5A_00_0F_A5_AA, 1'b1);
    drain();

    // Transmitter held busy before the response.
    force_busy = 1'b1;
    send_frame(40'hA5_02_02_00_00, 40'h5A_00_02_33_31, 1'b1);
    v0 = txv_cnt;
    repeat (50) @(negedge clk);
    check("busy_no_tx", txv_cnt - v0, 0);
    force_busy = 1'b0;
    drain();

    // Reset while waiting for busy to fall after response byte 2.
    v0 = txv_cnt;
    send_frame(40'hA5_02_03_00_01, 40'h5A_00_03_7E_7D, 1'b1);
    t = 0;
    while (!(txv_cnt - v0 >= 3 && tx_busy) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("rst_wait_timeout", (t >= 2000) ? 1 : 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("arst_rx_clear", rx_clear, 0);
    check("arst_tx_valid", tx_valid, 0);
    check("arst_tx_data", tx_data, 0);
    check("arst_ctrl", ctrl_reg, 0);
    check("arst_frame_err", frame_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    send_frame(40'hA5_02_03_00_01, 40'h5A_00_03_00_03, 1'b1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
